mem_bus_arbiter: RTL and testbench

Initiator (consumer) side of the `data_bus` line-transfer protocol. Arbitrates instruction-cache line fills and data-cache fills and write-backs onto the single bus to `main_memory`. Holds each request stable until the memory's one-cycle ready pulse, then returns a one-cycle acknowledge and line data to the winning client. Sits between the cache controllers and `main_memory` at top level.

---
 rtl/mem_bus_arbiter_pkg.sv | 12 +
 rtl/mem_bus_arbiter_if.sv | 15 +
 rtl/mem_bus_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 71 +++++++
 tb/tb_mem_bus_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// constants_pkg: shared widths, FSM state and bus operation types for the memory bus arbiter.
// Provides MBLEN (line width), PHY_LEN (physical address width), LINE_OFS and a line-alignment helper.
package constants_pkg;
    localparam int MBLEN = 128;
    localparam int PHY_LEN = 32;
    localparam int LINE_OFS = 4;
    typedef enum logic [1:0] {IDLE, BUS, ACK} arb_state_t;
    typedef enum logic {OP_LD, OP_ST} mem_op_t;
    function automatic logic [PHY_LEN-1:0] line_align(input logic [PHY_LEN-1:0] a);
        return {a[PHY_LEN-1:LINE_OFS], LINE_OFS'(0)};
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// data_bus: line-transfer bus between the arbiter (consumer/master) and main memory (slave).
// Signals: addr, ldp/srp (load/store present), srData (store line), ldData (load line), ldr/srr (ready pulses).
interface data_bus;
    import constants_pkg::*;
    logic [PHY_LEN-1:0] addr;
    logic ldp;
    logic srp;
    logic [MBLEN-1:0] srData;
    logic [MBLEN-1:0] ldData;
    logic ldr;
    logic srr;
    modport consumer(output addr, ldp, srp, srData, input ldData, ldr, srr);
    modport master(output addr, ldp, srp, srData, input ldData, ldr, srr);
    modport slave(input addr, ldp, srp, srData, output ldData, ldr, srr);
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker holding the last_dc flag.
// Ports: clk, rst, req_ic, req_dc, upd (record the current winner), grant (one-hot: [0]=icache, [1]=dcache).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ic,
    input  logic       req_dc,
    input  logic       upd,
    output logic [1:0] grant
);
    logic last_dc;
    // On a conflict dcache wins unless it was the client served last.
    assign grant[1] = req_dc && !(req_ic && last_dc);
    assign grant[0] = req_ic && !grant[1];
    // The winner is recorded at grant; grant is only consulted in IDLE, after the transaction has finished.
    always_ff @(posedge clk) begin
        if (rst) last_dc <= 1'b0;
        else if (upd) last_dc <= grant[1];
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates icache fills and dcache fills/write-backs onto the single data_bus.
// Ports: clk, rst; icache req/addr/ack/rdata; dcache req/we/addr/wdata/ack/rdata; busy; bus (data_bus.consumer).
module mem_bus_arbiter
    import constants_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ic_req,
    input  logic [PHY_LEN-1:0] ic_addr,
    output logic               ic_ack,
    output logic [MBLEN-1:0]   ic_rdata,
    input  logic               dc_req,
    input  logic               dc_we,
    input  logic [PHY_LEN-1:0] dc_addr,
    input  logic [MBLEN-1:0]   dc_wdata,
    output logic               dc_ack,
    output logic [MBLEN-1:0]   dc_rdata,
    output logic               busy,
    data_bus.consumer          bus
);
    arb_state_t state, state_n;
    mem_op_t op;
    logic sel_dc, start, ready, st;
    logic [1:0] grant;
    rr_arb2 u_arb (.clk(clk), .rst(rst), .req_ic(ic_req), .req_dc(dc_req), .upd(start), .grant(grant));
    assign start = state == IDLE && |grant;
    assign st = grant[1] && dc_we;
    // A ready of the wrong type for the outstanding op is ignored.
    assign ready = state == BUS && (op == OP_LD ? bus.ldr : bus.srr);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        state_n = start ? BUS : ready ? ACK : state == ACK ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            op <= OP_LD;
            sel_dc <= 1'b0;
            busy <= 1'b0;
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            ic_rdata <= '0;
            dc_rdata <= '0;
            bus.addr <= '0;
            bus.srData <= '0;
            bus.ldp <= 1'b0;
            bus.srp <= 1'b0;
        end else begin
            busy <= state_n != IDLE;
            ic_ack <= ready && !sel_dc;
            dc_ack <= ready && sel_dc;
            if (start) begin
                sel_dc <= grant[1];
                op <= st ? OP_ST : OP_LD;
                bus.addr <= line_align(grant[1] ? dc_addr : ic_addr);
                bus.srData <= st ? dc_wdata : '0;
                bus.ldp <= !st;
                bus.srp <= st;
            end
            if (ready) begin
                bus.ldp <= 1'b0;
                bus.srp <= 1'b0;
                if (op == OP_LD && sel_dc) dc_rdata <= bus.ldData;
                if (op == OP_LD && !sel_dc) ic_rdata <= bus.ldData;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench with a main_memory model (ready 8 cycles after first seeing a request).
module tb_mem_bus_arbiter;
    import constants_pkg::*;
    localparam logic [127:0] L3 = 128'h001080A3_003100B3_021081B3_00108093;
    localparam logic [127:0] L5 = 128'h55555555_AAAAAAAA_12345678_9ABCDEF0;
    localparam logic [127:0] L6 = 128'h66666666_01020304_05060708_090A0B0C;
    localparam logic [127:0] WB = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ic_req = 1'b0;
    logic [PHY_LEN-1:0] ic_addr = '0;
    logic ic_ack;
    logic [MBLEN-1:0] ic_rdata;
    logic dc_req = 1'b0;
    logic dc_we = 1'b0;
    logic [PHY_LEN-1:0] dc_addr = '0;
    logic [MBLEN-1:0] dc_wdata = '0;
    logic dc_ack;
    logic [MBLEN-1:0] dc_rdata;
    logic busy;
    logic inj = 1'b0;
    logic ldr_q = 1'b0;
    logic srr_q = 1'b0;
    logic [3:0] cnt = '0;
    logic [127:0] mem [16];
    int n_chk = 0;
    int n_pass = 0;
    int srp_hi = 0;
    int ic_acks = 0;
    int lat;
    int base;
    data_bus bus ();
    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata), .busy(busy), .bus(bus)
    );
    always #5 clk = ~clk;
    assign bus.ldr = ldr_q;
    assign bus.srr = srr_q | inj;
    assign bus.ldData = mem[bus.addr[7:4]];
    always @(posedge clk) begin
        if (!(bus.ldp || bus.srp)) begin
            cnt <= '0;
            ldr_q <= 1'b0;
            srr_q <= 1'b0;
        end else begin
            cnt <= cnt + 4'd1;
            ldr_q <= cnt == 4'd7 && bus.ldp;
            srr_q <= cnt == 4'd7 && bus.srp;
            if (cnt == 4'd7 && bus.srp) mem[bus.addr[7:4]] <= bus.srData;
        end
    end
    always @(negedge clk) begin
        if (bus.srp) srp_hi++;
        if (ic_ack) ic_acks++;
    end
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_ack(input bit dc, output int l);
        l = 0;
        while (l < 40) begin
            step();
            l++;
            if (dc ? dc_ack : ic_ack) break;
        end
    endtask
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 128'h0;
        mem[3] = L3;
        mem[5] = L5;
        mem[6] = L6;
        step(2);
        rst = 1'b0;
        chk("rst_ldp", bus.ldp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_ic_rdata", ic_rdata, 0);
        ic_req = 1'b1;
        ic_addr = 32'h30;
        base = srp_hi;
        step();
        chk("ic_ldp", bus.ldp, 1);
        chk("ic_busy", busy, 1);
        chk("ic_addr", bus.addr, 32'h30);
        wait_ack(0, lat);
        chk("ic_lat", lat + 1, 10);
        chk("ic_rdata", ic_rdata, L3);
        chk("ic_no_srp", srp_hi - base, 0);
        step();
        ic_req = 1'b0;
        chk("ic_ack_pulse", ic_ack, 0);
        dc_req = 1'b1;
        dc_we = 1'b1;
        dc_addr = 32'h40;
        dc_wdata = WB;
        step();
        chk("wb_srp", bus.srp, 1);
        chk("wb_ldp", bus.ldp, 0);
        chk("wb_srdata", bus.srData, WB);
        wait_ack(1, lat);
        chk("wb_lat", lat + 1, 10);
        chk("wb_rdata_hold", dc_rdata, 0);
        step();
        dc_req = 1'b0;
        dc_we = 1'b0;
        step();
        dc_req = 1'b1;
        wait_ack(1, lat);
        chk("rb_lat", lat, 10);
        chk("rb_rdata", dc_rdata, WB);
        step();
        dc_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ic_req = 1'b1;
        ic_addr = 32'h30;
        dc_req = 1'b1;
        dc_addr = 32'h50;
        step();
        chk("cont_dc_first", bus.addr, 32'h50);
        wait_ack(1, lat);
        chk("cont_dc_lat", lat + 1, 10);
        chk("cont_no_ic_ack", ic_ack, 0);
        chk("cont_dc_rdata", dc_rdata, L5);
        step();
        dc_req = 1'b0;
        chk("cont_ack1_ldp", bus.ldp, 0);
        step();
        chk("cont_ack2_ldp", bus.ldp, 1);
        chk("cont_ack2_addr", bus.addr, 32'h30);
        dc_req = 1'b1;
        dc_addr = 32'h60;
        wait_ack(0, lat);
        chk("cont_ic_lat", lat, 9);
        chk("cont_ic_rdata", ic_rdata, L3);
        step();
        ic_req = 1'b0;
        step();
        chk("cont_dc2_addr", bus.addr, 32'h60);
        wait_ack(1, lat);
        chk("cont_dc2_rdata", dc_rdata, L6);
        step();
        dc_req = 1'b0;
        ic_req = 1'b1;
        ic_addr = 32'h50;
        dc_req = 1'b1;
        dc_addr = 32'h30;
        step();
        chk("rr_ic_wins", bus.addr, 32'h50);
        wait_ack(0, lat);
        chk("rr_ic_rdata", ic_rdata, L5);
        step();
        ic_req = 1'b0;
        step();
        chk("rr_dc_next", bus.addr, 32'h30);
        wait_ack(1, lat);
        chk("rr_dc_rdata", dc_rdata, L3);
        step();
        dc_req = 1'b0;
        ic_req = 1'b1;
        ic_addr = 32'h60;
        step(5);
        rst = 1'b1;
        base = ic_acks;
        step();
        rst = 1'b0;
        ic_req = 1'b0;
        chk("rst_mid_ldp", bus.ldp, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdata", ic_rdata, 0);
        step(15);
        chk("rst_mid_no_ack", ic_acks - base, 0);
        ic_req = 1'b1;
        ic_addr = 32'h30;
        wait_ack(0, lat);
        chk("rst_after_lat", lat, 10);
        chk("rst_after_rdata", ic_rdata, L3);
        step();
        ic_req = 1'b0;
        dc_req = 1'b1;
        dc_we = 1'b0;
        dc_addr = 32'h4C;
        step();
        chk("align_addr", bus.addr, 32'h40);
        dc_addr = 32'h80;
        dc_we = 1'b1;
        dc_wdata = L6;
        step(5);
        chk("stable_addr", bus.addr, 32'h40);
        chk("stable_ldp", bus.ldp, 1);
        chk("stable_srp", bus.srp, 0);
        wait_ack(1, lat);
        chk("stable_lat", lat, 4);
        chk("stable_rdata", dc_rdata, WB);
        step();
        dc_req = 1'b0;
        dc_we = 1'b0;
        chk("dc_ack_pulse", dc_ack, 0);
        ic_req = 1'b1;
        ic_addr = 32'h50;
        step(4);
        inj = 1'b1;
        step();
        inj = 1'b0;
        chk("wrong_rdy_ack", ic_ack, 0);
        chk("wrong_rdy_ldp", bus.ldp, 1);
        wait_ack(0, lat);
        chk("wrong_rdy_lat", lat, 5);
        chk("wrong_rdy_rdata", ic_rdata, L5);
        step();
        ic_req = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
